// File: rtl/bpred_2b_table.sv
// Direction predictor: table of 2-bit saturating counters indexed by pc[IDX_W:1],
// combinational read at fetch, registered update from execute, plus a mispredict counter.

module bpred_2b_entry (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       taken,
    output logic [1:0] state
);
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= 2'b01;
        end else if (en) begin
            if (taken && state != 2'b11)
                state <= state + 2'b01;
            else if (!taken && state != 2'b00)
                state <= state - 2'b01;
        end
    end
endmodule

module bpred_2b_table #(
    parameter int IDX_W = 3,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [15:0]      pc_fetch,
    output logic             pred_taken,
    output logic [1:0]       pred_state,
    input  logic             upd_en,
    input  logic [15:0]      upd_pc,
    input  logic             upd_taken,
    input  logic             upd_mispred,
    output logic [CNT_W-1:0] mispred_cnt
);
    localparam int ENTRIES = 1 << IDX_W;

    logic [ENTRIES-1:0][1:0] table_q;
    logic [ENTRIES-1:0]      we;
    logic [IDX_W-1:0]        fetch_idx;
    logic [IDX_W-1:0]        upd_idx;

    // Bit 0 is dropped: instructions are halfword aligned.
    assign fetch_idx = pc_fetch[IDX_W:1];
    assign upd_idx   = upd_pc[IDX_W:1];

    genvar i;
    generate
        for (i = 0; i < ENTRIES; i++) begin : g_entry
            assign we[i] = upd_en && (upd_idx == IDX_W'(i));
            bpred_2b_entry u_entry (
                .clk   (clk),
                .rst   (rst),
                .en    (we[i]),
                .taken (upd_taken),
                .state (table_q[i])
            );
        end
    endgenerate

    // No bypass: a same-cycle update is visible only after the edge.
    assign pred_state = table_q[fetch_idx];
    assign pred_taken = pred_state[1];

    always_ff @(posedge clk) begin
        if (rst)
            mispred_cnt <= '0;
        else if (upd_en && upd_mispred && mispred_cnt != {CNT_W{1'b1}})
            mispred_cnt <= mispred_cnt + 1'b1;
    end
endmodule

// File: tb/tb_bpred_2b_table.sv
// Scoreboard bench for bpred_2b_table: stimulus pushes expected outputs from an
// integer reference model, a negedge monitor pops and compares.

module tb_bpred_2b_table;
    localparam int IDX_W = 3;
    localparam int CNT_W = 4;
    localparam int ENTRIES = 1 << IDX_W;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk;
    logic             rst;
    logic [15:0]      pc_fetch;
    logic             pred_taken;
    logic [1:0]       pred_state;
    logic             upd_en;
    logic [15:0]      upd_pc;
    logic             upd_taken;
    logic             upd_mispred;
    logic [CNT_W-1:0] mispred_cnt;

    bpred_2b_table #(.IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .pc_fetch    (pc_fetch),
        .pred_taken  (pred_taken),
        .pred_state  (pred_state),
        .upd_en      (upd_en),
        .upd_pc      (upd_pc),
        .upd_taken   (upd_taken),
        .upd_mispred (upd_mispred),
        .mispred_cnt (mispred_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int   id;
        int   st;
        int   tk;
        int   mc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   step_id = 0;

    // Reference model: plain integers per table slot.
    int mdl[ENTRIES];
    int mcnt;

    function automatic int idx_of(input logic [15:0] pc);
        return (int'(pc) / 2) % ENTRIES;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < ENTRIES; k++) mdl[k] = 1;
        mcnt = 0;
    endtask

    // Drive one cycle: expected outputs reflect the table before this edge.
    task automatic step(input logic r, input logic en, input logic [15:0] upc,
                        input logic tk, input logic mp, input logic [15:0] fpc);
        exp_t e;
        int   u;
        #1;
        rst = r; upd_en = en; upd_pc = upc; upd_taken = tk;
        upd_mispred = mp; pc_fetch = fpc;
        e.id = step_id;
        e.st = mdl[idx_of(fpc)];
        e.tk = (e.st >= 2) ? 1 : 0;
        e.mc = mcnt;
        exp_q.push_back(e);
        step_id++;
        if (r) begin
            model_reset();
        end else if (en) begin
            u = idx_of(upc);
            if (tk) mdl[u] = (mdl[u] < 3) ? mdl[u] + 1 : 3;
            else    mdl[u] = (mdl[u] > 0) ? mdl[u] - 1 : 0;
            if (mp) mcnt = (mcnt < CNT_MAX) ? mcnt + 1 : CNT_MAX;
        end
        @(posedge clk);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (int'(pred_state) !== e.st) begin
                errors++;
                $display("FAIL pred_state step %0d: got %0d expected %0d", e.id, pred_state, e.st);
            end
            checks++;
            if (int'(pred_taken) !== e.tk) begin
                errors++;
                $display("FAIL pred_taken step %0d: got %0d expected %0d", e.id, pred_taken, e.tk);
            end
            checks++;
            if (int'(mispred_cnt) !== e.mc) begin
                errors++;
                $display("FAIL mispred_cnt step %0d: got %0d expected %0d", e.id, mispred_cnt, e.mc);
            end
        end
    end

    initial begin
        rst = 1'b1; upd_en = 1'b0; upd_pc = '0; upd_taken = 1'b0;
        upd_mispred = 1'b0; pc_fetch = '0;
        @(posedge clk);
        model_reset();

        // Reset read sweep
        for (int k = 0; k < ENTRIES; k++) step(0, 0, 16'h0, 0, 0, 16'(2 * k));
        // Saturate up entry 3, neighbour untouched
        for (int k = 0; k < 4; k++) step(0, 1, 16'h0006, 1, 0, 16'h0006);
        step(0, 0, 16'h0, 0, 0, 16'h0006);
        step(0, 0, 16'h0, 0, 0, 16'h0004);
        // Saturate down via alias 0x0016
        for (int k = 0; k < 4; k++) step(0, 1, 16'h0016, 0, 0, 16'h0006);
        step(0, 0, 16'h0, 0, 0, 16'h0016);
        // Same-cycle read/write on entry 5
        step(0, 1, 16'h000A, 1, 0, 16'h000A);
        step(0, 0, 16'h0, 0, 0, 16'h000A);
        // Mispredict saturation, then ignored when upd_en=0
        for (int k = 0; k < 17; k++) step(0, 1, 16'h0002, k[0], 1, 16'h0002);
        for (int k = 0; k < 3; k++) step(0, 0, 16'h0002, 1, 1, 16'h0002);
        // Reset wins over a same-cycle update, updates resume after
        step(0, 1, 16'h0004, 1, 0, 16'h0004);
        step(1, 1, 16'h0004, 1, 1, 16'h0004);
        step(0, 1, 16'h0004, 1, 1, 16'h0004);
        step(0, 0, 16'h0, 0, 0, 16'h0004);
        // Random traffic
        for (int k = 0; k < 400; k++) begin
            step(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0),
                 16'($urandom), 1'($urandom), 1'($urandom), 16'($urandom));
        end

        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
